// File: rtl/bram_pkg.sv
// Shared types and constants for the matrix-buffer BRAM write/read path.
package bram_pkg;

    localparam int unsigned BURST_DEPTH = 4;
    localparam int unsigned READ_LAT    = 1;

    // Burst reader FSM
    typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

    // Upstream write controller FSM
    typedef enum logic [1:0] {WR_IDLE, WR_BURST, WR_DONE} wr_state_t;

    // True when one more read may be issued without overflowing the 2-entry buffer.
    // A pop in the same cycle frees a slot, which keeps one word per cycle flowing.
    function automatic logic has_credit(input logic in_flight, input logic [1:0] count,
                                        input logic pop);
        logic [2:0] occ;
        occ = {2'b00, in_flight} + {1'b0, count} - {2'b00, pop};
        return occ < 3'd2;
    endfunction

endpackage

// File: rtl/bram_burst_reader_if.sv
// BRAM read port plus valid/ready output stream of the burst reader.
interface bram_burst_reader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
) ();

    logic [ADDR_W-1:0] rd_addr;
    logic              ren;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output rd_addr, ren, out_data, out_valid, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_addr, ren, out_data, out_valid, out_last,
        output rd_data, out_ready
    );

endinterface

// File: rtl/bram_out_fifo.sv
// Two-entry FIFO holding {last, data} words returned from the BRAM.
module bram_out_fifo #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage, pointers and occupancy; caller guarantees no push when full, no pop when empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Head of queue is presented directly; it only changes on pop
    always_comb begin
        dout  = mem[rd_ptr];
        empty = (count == 2'd0);
    end

endmodule

// File: rtl/bram_burst_reader.sv
// Counts a DEPTH-word write burst, then reads it back in address order and streams it out.
module bram_burst_reader
    import bram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = BURST_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wen,
    bram_burst_reader_if.master    bus,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   overrun
);

    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rd_state_t         state;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              in_flight;
    logic              in_flight_last;

    logic              issue;
    logic              pop;
    logic              drained;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [DATA_W:0]   fifo_dout;

    // Read issue, handshake and completion decode from registered state
    always_comb begin
        pop        = !fifo_empty && bus.out_ready;
        issue      = (state == READ) && has_credit(in_flight, fifo_count, pop);
        drained    = fifo_empty && !in_flight;
        burst_done = (state == DRAIN) && drained;
        busy       = (state != IDLE);
        bus.ren    = issue;
        bus.rd_addr = rd_addr;
    end

    // Control FSM with write counter, read address, in-flight tracking and sticky overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wr_cnt         <= '0;
            rd_addr        <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            in_flight      <= issue;
            in_flight_last <= issue && (rd_addr == LAST_ADDR);
            // Includes the DRAIN->IDLE cycle; such a wen is not counted
            if (wen && state != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (wr_cnt == FULL_CNT) begin
                        state   <= READ;
                        wr_cnt  <= '0;
                        rd_addr <= '0;
                    end else if (wen) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (rd_addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BRAM data is valid the cycle after ren, so in_flight is the push strobe
    bram_out_fifo #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_flight),
        .pop   (pop),
        .din   ({in_flight_last, bus.rd_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Stream outputs come straight from the buffer head
    always_comb begin
        bus.out_valid = !fifo_empty;
        bus.out_last  = fifo_dout[DATA_W];
        bus.out_data  = fifo_dout[DATA_W-1:0];
    end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Self-checking bench for bram_burst_reader: BRAM model, random stimulus, queue scoreboard.
module tb_bram_burst_reader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic wen = 1'b0;
    logic busy, burst_done, overrun;

    always #5 clk = ~clk;

    bram_burst_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    bram_burst_reader #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wen       (wen),
        .bus       (bus),
        .busy      (busy),
        .burst_done(burst_done),
        .overrun   (overrun)
    );

    // BRAM model: one-cycle read latency
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) if (bus.ren) bus.rd_data <= mem[bus.rd_addr];

    int n_cmp = 0;
    int n_fail = 0;

    // Per-cycle samples and statistics
    logic              s_ren, s_valid, s_last, s_busy, s_done, s_ovr;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic [DATA_W-1:0] exp_data[$], rx_data[$];
    logic              exp_last[$], rx_last[$];
    int                acc_cyc[$];
    int cyc = 0;
    int ren_cnt, ren_stall, done_cnt, hold_viol;
    int first_busy_cyc, first_valid_cyc, first_ren_cyc;
    logic [ADDR_W-1:0] first_ren_addr;
    logic              hold_pend;
    logic [DATA_W-1:0] hold_data;

    task automatic clear_stats();
        exp_data.delete(); exp_last.delete();
        rx_data.delete(); rx_last.delete(); acc_cyc.delete();
        ren_cnt = 0; ren_stall = 0; done_cnt = 0; hold_viol = 0;
        first_busy_cyc = -1; first_valid_cyc = -1; first_ren_cyc = -1;
        first_ren_addr = '0; hold_pend = 1'b0; hold_data = '0;
    endtask

    // One clock: drive inputs after negedge, sample settled outputs before posedge
    task automatic tick(input logic w, input logic rdy);
        @(negedge clk);
        wen = w;
        bus.out_ready = rdy;
        #1;
        cyc++;
        s_ren = bus.ren; s_addr = bus.rd_addr; s_valid = bus.out_valid;
        s_data = bus.out_data; s_last = bus.out_last; s_busy = busy;
        s_done = burst_done; s_ovr = overrun;
        if (hold_pend && (!s_valid || s_data !== hold_data)) hold_viol++;
        hold_pend = s_valid && !rdy;
        hold_data = s_data;
        if (s_valid && rdy) begin
            rx_data.push_back(s_data); rx_last.push_back(s_last); acc_cyc.push_back(cyc);
        end
        if (s_ren) begin
            ren_cnt++;
            if (!rdy) ren_stall++;
            if (first_ren_cyc < 0) begin first_ren_cyc = cyc; first_ren_addr = s_addr; end
        end
        if (s_busy && first_busy_cyc < 0) first_busy_cyc = cyc;
        if (s_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (s_done) done_cnt++;
    endtask

    // Fill the BRAM; a burst is expected back in address order, last flag on the top word
    task automatic load_burst(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = rnd ? DATA_W'($urandom) : DATA_W'(32'hA0 + i);
            exp_data.push_back(mem[i]);
            exp_last.push_back(i == DEPTH - 1);
        end
    endtask

    task automatic issue_wens(input int n);
        repeat (n) tick(1'b1, 1'b1);
    endtask

    // mode 0: ready high, 1: ready low for 6 cycles then high, 2: random ready
    task automatic drain(input int mode);
        bit   seen = 0;
        int   k = 0;
        logic rdy;
        while (!seen && k < 60) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(k >= 6) : 1'($urandom_range(0, 1));
            tick(1'b0, rdy);
            seen = s_done;
            k++;
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL drain_timeout: burst_done not seen in %0d cycles", k); end
        tick(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp += 8;
        if (bus.ren !== 1'b0) begin n_fail++; $display("FAIL rst_ren: got %b want 0", bus.ren); end
        if (bus.rd_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", bus.rd_addr); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b want 0", bus.out_last); end
        if (bus.out_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (burst_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", burst_done); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_burst();
        clear_stats();
        load_burst(0);
        issue_wens(4);
        drain(0);
        n_cmp++;
        if (rx_data.size() != 4) begin n_fail++; $display("FAIL single_count: got %0d want 4", rx_data.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp += 2;
            if (i >= rx_data.size() || rx_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i,
                                   (i < rx_data.size()) ? rx_data[i] : 'x, exp_data[i]);
            end
            if (i >= rx_last.size() || rx_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL single_last[%0d]: want %b", i, exp_last[i]);
            end
        end
        n_cmp += 5;
        if (first_ren_addr !== '0) begin n_fail++; $display("FAIL single_first_addr: got %0d want 0", first_ren_addr); end
        if (first_valid_cyc - first_busy_cyc != 2) begin
            n_fail++; $display("FAIL single_latency: got %0d want 2", first_valid_cyc - first_busy_cyc);
        end
        if (acc_cyc.size() != 4 || acc_cyc[3] - acc_cyc[0] != 3) begin
            n_fail++; $display("FAIL single_throughput: accepts not on 4 consecutive cycles");
        end
        if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d want 1", done_cnt); end
        if (s_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", s_busy); end
    endtask

    task automatic test_backpressure();
        clear_stats();
        load_burst(0);
        issue_wens(4);
        drain(1);
        n_cmp += 3;
        if (ren_stall > 2) begin n_fail++; $display("FAIL stall_reads: got %0d want <=2", ren_stall); end
        if (hold_viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d want 0 changes", hold_viol); end
        if (rx_data.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", rx_data.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= rx_data.size() || rx_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL stall_data[%0d]: want %h", i, exp_data[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        for (int b = 0; b < 3; b++) begin
            load_burst(1);
            issue_wens(4);
            drain(2);
        end
        n_cmp += 3;
        if (rx_data.size() != 12) begin n_fail++; $display("FAIL b2b_count: got %0d want 12", rx_data.size()); end
        if (done_cnt != 3) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 3", done_cnt); end
        if (hold_viol != 0) begin n_fail++; $display("FAIL b2b_hold: got %0d want 0", hold_viol); end
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (i >= rx_data.size() || rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL b2b_word[%0d]: want %h last %b", i, exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int ren_before;
        clear_stats();
        load_burst(1);
        issue_wens(4);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        drain(0);
        n_cmp += 3;
        if (s_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", s_ovr); end
        if (rx_data.size() != 4) begin n_fail++; $display("FAIL ovr_count: got %0d want 4", rx_data.size()); end
        if (done_cnt != 1) begin n_fail++; $display("FAIL ovr_done: got %0d want 1", done_cnt); end
        // The stray wen must not have been counted: three more must not start a burst
        ren_before = ren_cnt;
        issue_wens(3);
        repeat (5) tick(1'b0, 1'b1);
        n_cmp += 2;
        if (ren_cnt != ren_before) begin n_fail++; $display("FAIL ovr_wrcnt: got %0d reads want 0", ren_cnt - ren_before); end
        if (s_busy !== 1'b0) begin n_fail++; $display("FAIL ovr_idle_busy: got %b want 0", s_busy); end
        load_burst(1);
        issue_wens(1);
        drain(0);
        n_cmp += 2;
        if (s_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", s_ovr); end
        if (rx_data.size() != 8) begin n_fail++; $display("FAIL ovr_total: got %0d want 8", rx_data.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= rx_data.size() || rx_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL ovr_data[%0d]: want %h", i, exp_data[i]);
            end
        end
    endtask

    task automatic test_abort();
        int k = 0;
        clear_stats();
        load_burst(1);
        issue_wens(4);
        while (rx_data.size() < 2 && k < 20) begin tick(1'b0, 1'b1); k++; end
        #1 reset = 1'b0;
        #1;
        n_cmp += 8;
        if (bus.ren !== 1'b0) begin n_fail++; $display("FAIL abort_ren: got %b want 0", bus.ren); end
        if (bus.rd_addr !== '0) begin n_fail++; $display("FAIL abort_addr: got %0d want 0", bus.rd_addr); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", bus.out_valid); end
        if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL abort_last: got %b want 0", bus.out_last); end
        if (bus.out_data !== '0) begin n_fail++; $display("FAIL abort_data: got %h want 0", bus.out_data); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (burst_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", burst_done); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL abort_overrun: got %b want 0", overrun); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_stats();
        load_burst(1);
        issue_wens(4);
        drain(0);
        n_cmp += 2;
        if (first_ren_addr !== '0) begin n_fail++; $display("FAIL abort_restart_addr: got %0d want 0", first_ren_addr); end
        if (rx_data.size() != 4) begin n_fail++; $display("FAIL abort_restart_count: got %0d want 4", rx_data.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= rx_data.size() || rx_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL abort_restart_data[%0d]: want %h", i, exp_data[i]);
            end
        end
    endtask

    task automatic test_partial_burst();
        clear_stats();
        issue_wens(3);
        repeat (10) tick(1'b0, 1'b1);
        n_cmp += 2;
        if (ren_cnt != 0) begin n_fail++; $display("FAIL partial_ren: got %0d want 0", ren_cnt); end
        if (first_busy_cyc >= 0) begin n_fail++; $display("FAIL partial_busy: got 1 want 0"); end
        load_burst(1);
        issue_wens(1);
        drain(0);
        n_cmp += 2;
        if (done_cnt != 1) begin n_fail++; $display("FAIL partial_done: got %0d want 1", done_cnt); end
        if (rx_data.size() != 4) begin n_fail++; $display("FAIL partial_count: got %0d want 4", rx_data.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= rx_data.size() || rx_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL partial_data[%0d]: want %h", i, exp_data[i]);
            end
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_burst();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_partial_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
